// File: rtl/csel_pkg.sv
// rtl/csel_pkg.sv - sizing helpers and saturation constants for the pipelined carry-select adder
//
// Purpose: shared compile-time helpers used to size the segment and stage
// structure of csel_pipe_adder and to build its saturation limits.
// Ports: none (package).
package csel_pkg;

   localparam int MAX_W = 64;

   // Number of carry-select segments needed to cover sum_w bits.
   function automatic int nseg(input int sum_w, input int seg_w);
      return (sum_w + seg_w - 1) / seg_w;
   endfunction

   // Number of register stages when sps segments are evaluated per stage.
   function automatic int nstg(input int n, input int sps);
      return (n + sps - 1) / sps;
   endfunction

   // Largest positive value of a w-bit two's complement number.
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   // Most negative value of a w-bit two's complement number.
   function automatic logic [MAX_W-1:0] sat_min(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/csel_segment.sv
// rtl/csel_segment.sv - combinational carry-select adder slice
//
// Purpose: adds one W-bit slice both ways (carry-in 0 and 1) and picks the
// result on the real carry-in.
// Ports:
//   a, b  [W-1:0] slice operands
//   cin          carry into the slice
//   s     [W-1:0] slice sum
//   cout         carry out of the slice MSB
//   cmsb         carry into the slice MSB (used for signed overflow on the top slice)
module csel_segment #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         cmsb
);

   logic [W:0] sum0;
   logic [W:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + (W+1)'(1);

   assign s    = cin ? sum1[W-1:0] : sum0[W-1:0];
   assign cout = cin ? sum1[W]     : sum0[W];

   // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
   assign cmsb = s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - pipelined carry-select signed adder with overflow flag and optional saturation
//
// Purpose: sign-extends in_a/in_b to SUM_W, adds them in SEG_W carry-select
// slices with a register stage every SEGS_PER_STAGE slices, and delivers the
// (optionally saturated) sum under a valid/ready handshake.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready depends only on the output side)
//   in_a [A_W-1:0]       signed operand A
//   in_b [B_W-1:0]       signed operand B
//   out_valid, out_ready output handshake
//   out_sum [SUM_W-1:0]  wrapped or saturated signed sum
//   out_ovf              signed overflow flag for out_sum
module csel_pipe_adder
   import csel_pkg::*;
#(
   parameter int A_W            = 27,
   parameter int B_W            = 28,
   parameter int SUM_W          = 28,
   parameter int SEG_W          = 4,
   parameter int SEGS_PER_STAGE = 2,
   parameter int SAT            = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam int NSEG  = nseg(SUM_W, SEG_W);
   localparam int NSTG  = nstg(NSEG, SEGS_PER_STAGE);
   localparam int TOP_W = SUM_W - (NSEG - 1) * SEG_W;

   localparam logic [SUM_W-1:0] SMAX = SUM_W'(sat_max(SUM_W));
   localparam logic [SUM_W-1:0] SMIN = SUM_W'(sat_min(SUM_W));

   logic             adv;
   logic [SUM_W-1:0] a_ext;
   logic [SUM_W-1:0] b_ext;

   // Bank s holds the state after stage s: the completed low sum bits, the
   // carry out of the stage, and the operands skewed for the stage after it.
   logic [SUM_W-1:0] a_q   [NSTG];
   logic [SUM_W-1:0] b_q   [NSTG];
   logic [SUM_W-1:0] sum_q [NSTG];
   logic             c_q   [NSTG];
   logic [NSTG-1:0]  v_q;
   logic [NSTG-1:0]  sgn_q;
   logic             ovf_q;

   logic [SUM_W-1:0] sum_nxt [NSTG];
   logic             c_nxt   [NSTG];
   logic             ovf_nxt;

   assign a_ext = SUM_W'(signed'(in_a));
   assign b_ext = SUM_W'(signed'(in_b));

   // One enable for the whole pipe: it moves whenever the output slot is free
   // or being drained this cycle.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      localparam int FS = s * SEGS_PER_STAGE;
      localparam int NS = (NSEG - FS < SEGS_PER_STAGE) ? NSEG - FS : SEGS_PER_STAGE;
      localparam int LO = FS * SEG_W;
      localparam int HI = (FS + NS == NSEG) ? SUM_W : (FS + NS) * SEG_W;

      logic [HI-1:LO]    a_in;
      logic [HI-1:LO]    b_in;
      logic [HI-LO-1:0]  st_sum;
      logic [NS:0]       cc;

      if (s == 0) begin : g_first
         assign a_in  = a_ext[HI-1:LO];
         assign b_in  = b_ext[HI-1:LO];
         assign cc[0] = 1'b0;
         assign sum_nxt[s] = SUM_W'(st_sum);
      end else begin : g_rest
         assign a_in  = a_q[s-1][HI-1:LO];
         assign b_in  = b_q[s-1][HI-1:LO];
         assign cc[0] = c_q[s-1];
         // Bits above the completed range are still zero in the previous bank.
         assign sum_nxt[s] = sum_q[s-1] | (SUM_W'(st_sum) << LO);
      end

      for (genvar j = 0; j < NS; j++) begin : g_seg
         localparam int IDX = FS + j;
         localparam int SW  = (IDX == NSEG - 1) ? TOP_W : SEG_W;
         localparam int SLO = IDX * SEG_W;

         logic cm;

         csel_segment #(.W(SW)) u_seg (
            .a    (a_in[SLO +: SW]),
            .b    (b_in[SLO +: SW]),
            .cin  (cc[j]),
            .s    (st_sum[SLO-LO +: SW]),
            .cout (cc[j+1]),
            .cmsb (cm)
         );

         if (IDX == NSEG - 1) begin : g_top
            assign ovf_nxt = cm ^ cc[j+1];
         end else begin : g_low
            logic unused_cm;
            assign unused_cm = cm;
         end
      end

      assign c_nxt[s] = cc[NS];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         sgn_q <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < NSTG; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            sum_q[i] <= '0;
            c_q[i]   <= 1'b0;
         end
      end else if (adv) begin
         v_q[0]   <= in_valid;
         sgn_q[0] <= a_ext[SUM_W-1];
         a_q[0]   <= a_ext;
         b_q[0]   <= b_ext;
         for (int i = 1; i < NSTG; i++) begin
            v_q[i]   <= v_q[i-1];
            sgn_q[i] <= sgn_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
         end
         for (int i = 0; i < NSTG; i++) begin
            sum_q[i] <= sum_nxt[i];
            c_q[i]   <= c_nxt[i];
         end
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = v_q[NSTG-1];
   assign out_ovf   = ovf_q;

   // On overflow both operands share A's sign, so A's sign picks the rail.
   assign out_sum = ((SAT != 0) && ovf_q) ? (sgn_q[NSTG-1] ? SMIN : SMAX)
                                          : sum_q[NSTG-1];

endmodule

// File: tb/tb_csel_pipe_adder.sv
// tb/tb_csel_pipe_adder.sv - scoreboard bench for csel_pipe_adder (wrap, saturate, stall, reset, parameter sweep)
module tb_csel_pipe_adder;

   typedef struct {
      logic [63:0] sum;
      bit          ovf;
      int          t;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst;
   logic        in_valid, out_ready;
   logic [26:0] in_a;
   logic [27:0] in_b;
   logic        in_ready0, out_valid0, ovf0;
   logic [27:0] sum0;
   logic        in_ready1, out_valid1, ovf1;
   logic [27:0] sum1;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf;
   logic [29:0] s_in_a, s_in_b, s_sum;

   csel_pipe_adder #(.SAT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
      .out_sum(sum0), .out_ovf(ovf0)
   );

   csel_pipe_adder #(.SAT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
      .out_sum(sum1), .out_ovf(ovf1)
   );

   csel_pipe_adder #(.A_W(30), .B_W(30), .SUM_W(30), .SEG_W(4),
                     .SEGS_PER_STAGE(3), .SAT(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_sum(s_sum), .out_ovf(s_ovf)
   );

   exp_t q0[$], q1[$], q2[$];
   exp_t e0, e1, e2;
   int   total = 0;
   int   bad   = 0;

   logic [29:0] ext_v [5] = '{30'h20000000, 30'h1FFFFFFF, 30'h0, 30'h3FFFFFFF, 30'h1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer sum, then wrap or clamp to w bits.
   function automatic void model(input longint sa, input longint sb, input int w, input bit sat,
                                 output logic [63:0] s, output bit ovf);
      longint t, mx, mn;
      t   = sa + sb;
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -mx - 1;
      ovf = (t > mx) || (t < mn);
      if (sat && ovf) t = (t > mx) ? mx : mn;
      s = 64'(t) & ((64'd1 << w) - 64'd1);
   endfunction

   // Monitors: pop on each output transfer (sampled at the falling edge).
   always @(negedge clk) begin
      if (!rst && out_valid0 && out_ready) begin
         chk("d0_queue_nonempty", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) begin
            e0 = q0.pop_front();
            chk("d0_sum", 64'(sum0), e0.sum);
            chk("d0_ovf", 64'(ovf0), 64'(e0.ovf));
            if (e0.lat != 0) chk("d0_latency", 64'(cyc - e0.t), 64'(e0.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready) begin
         chk("d1_queue_nonempty", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            chk("d1_sum", 64'(sum1), e1.sum);
            chk("d1_ovf", 64'(ovf1), 64'(e1.ovf));
            if (e1.lat != 0) chk("d1_latency", 64'(cyc - e1.t), 64'(e1.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && s_out_valid && s_out_ready) begin
         chk("d2_queue_nonempty", 64'(q2.size() != 0), 64'd1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            chk("d2_sum", 64'(s_sum), e2.sum);
            chk("d2_ovf", 64'(s_ovf), 64'(e2.ovf));
            if (e2.lat != 0) chk("d2_latency", 64'(cyc - e2.t), 64'(e2.lat));
         end
      end
   end

   task automatic step01(input logic [26:0] a, input logic [27:0] b, input logic v,
                         input logic ordy, input int lat, output logic acc);
      logic [63:0] s;
      bit          o;
      @(posedge clk);
      #1;
      in_a = a; in_b = b; in_valid = v; out_ready = ordy;
      @(negedge clk);
      acc = v && in_ready0 && !rst;
      if (acc) begin
         model(longint'($signed(a)), longint'($signed(b)), 28, 1'b0, s, o);
         q0.push_back('{sum: s, ovf: o, t: cyc, lat: lat});
         model(longint'($signed(a)), longint'($signed(b)), 28, 1'b1, s, o);
         q1.push_back('{sum: s, ovf: o, t: cyc, lat: lat});
      end
   endtask

   task automatic step2(input logic [29:0] a, input logic [29:0] b, input logic v);
      logic [63:0] s;
      bit          o;
      @(posedge clk);
      #1;
      s_in_a = a; s_in_b = b; s_in_valid = v; s_out_ready = 1'b1;
      @(negedge clk);
      if (v && s_in_ready && !rst) begin
         model(longint'($signed(a)), longint'($signed(b)), 30, 1'b1, s, o);
         q2.push_back('{sum: s, ovf: o, t: cyc, lat: 3});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout cycles=%0d", cyc);
      $fatal(1, "time limit");
   end

   logic        acc;
   logic [27:0] held;
   logic [26:0] ra [16];
   logic [27:0] rb [16];
   int          sent, j;
   logic [29:0] xa, xb;

   initial begin
      // Reset with an operand pair offered: it must not be taken.
      rst = 1'b1; in_valid = 1'b1; in_a = 27'd5; in_b = 28'd7; out_ready = 1'b1;
      s_in_valid = 1'b1; s_in_a = 30'd3; s_in_b = 30'd4; s_out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid0), 64'd0);
      chk("rst_out_sum",   64'(sum0),       64'd0);
      chk("rst_out_ovf",   64'(ovf0),       64'd0);
      chk("rst_in_ready",  64'(in_ready0),  64'd1);
      chk("rst_sat_sum",   64'(sum1),       64'd0);
      chk("rst_sweep_valid", 64'(s_out_valid), 64'd0);
      chk("rst_sweep_ready", 64'(s_in_ready),  64'd1);
      for (int i = 0; i < 6; i++) begin
         step01(27'd0, 28'd0, 1'b0, 1'b1, 0, acc);
         chk("rst_no_accept", 64'(out_valid0 | s_out_valid), 64'd0);
      end

      // Directed: carry ripple with sign extension, then both overflow directions.
      step01(27'h7FFFFFF, 28'h0000005, 1'b1, 1'b1, 4, acc);
      step01(27'h3FFFFFF, 28'h0000001, 1'b1, 1'b1, 4, acc);
      step01(27'h0000001, 28'h7FFFFFF, 1'b1, 1'b1, 4, acc);
      step01(27'h7FFFFFF, 28'h8000000, 1'b1, 1'b1, 4, acc);
      for (int i = 0; i < 7; i++) step01(27'd0, 28'd0, 1'b0, 1'b1, 0, acc);
      chk("directed_drained0", 64'(q0.size()), 64'd0);
      chk("directed_drained1", 64'(q1.size()), 64'd0);

      // 16 back-to-back random pairs with out_ready low in cycles 5..7.
      for (int i = 0; i < 16; i++) begin
         ra[i] = 27'($urandom);
         rb[i] = 28'($urandom);
      end
      sent = 0; j = 0; held = '0;
      while (sent < 16 && j < 100) begin
         step01(ra[sent], rb[sent], 1'b1, !(j >= 5 && j <= 7), 0, acc);
         if (acc) sent++;
         if (j >= 5 && j <= 7) begin
            chk("stall_in_ready",  64'(in_ready0),  64'd0);
            chk("stall_out_valid", 64'(out_valid0), 64'd1);
            if (j == 5) held = sum0;
            else chk("stall_sum_stable", 64'(sum0), 64'(held));
         end
         j++;
      end
      chk("stream_all_sent", 64'(sent), 64'd16);
      for (int i = 0; i < 8; i++) step01(27'd0, 28'd0, 1'b0, 1'b1, 0, acc);
      chk("stream_drained0", 64'(q0.size()), 64'd0);
      chk("stream_drained1", 64'(q1.size()), 64'd0);

      // Reset while three items are in flight: none of them may come out.
      for (int i = 0; i < 3; i++) step01(27'($urandom), 28'($urandom), 1'b1, 1'b1, 0, acc);
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 8; i++) begin
         step01(27'd0, 28'd0, 1'b0, 1'b1, 0, acc);
         chk("midrst_no_output0", 64'(out_valid0), 64'd0);
         chk("midrst_no_output1", 64'(out_valid1), 64'd0);
      end

      // Parameter sweep: 30-bit, 3 stages, 2-bit top slice, saturating.
      for (int i = 0; i < 1000; i++) begin
         xa = ($urandom_range(0, 3) == 0) ? ext_v[$urandom_range(0, 4)] : 30'($urandom);
         xb = ($urandom_range(0, 3) == 0) ? ext_v[$urandom_range(0, 4)] : 30'($urandom);
         step2(xa, xb, $urandom_range(0, 9) != 0);
      end
      for (int i = 0; i < 6; i++) step2(30'd0, 30'd0, 1'b0);
      chk("sweep_drained", 64'(q2.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
